control_sequencer: RTL and testbench

//  Hardwired control unit that drives the datapath Bus control inputs, in place of the

---
 rtl/control_sequencer_if.sv | 42 ++++
 rtl/control_sequencer.sv | 170 +++++++++++++++++
 tb/tb_control_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Run/memory handshake, IR contents and datapath Bus control
//                lines between the hardwired control unit and the datapath.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_sequencer_if #(
   parameter int OPW  = 5,
   parameter int REGW = 4
);
   logic            run;
   logic            mem_ready;
   logic [31:0]     ir;

   logic            PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin, Yin;
   logic            Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
   logic            rout_en;
   logic [REGW-1:0] rout_sel;
   logic            rin_en;
   logic [REGW-1:0] rin_sel;
   logic [OPW-1:0]  ALU;
   logic            busy;
   logic            halted;

   // Control unit side
   modport master (
      input  run, mem_ready, ir,
      output PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin, Yin,
      output Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
      output rout_en, rout_sel, rin_en, rin_sel, ALU, busy, halted
   );

   // Datapath side
   modport slave (
      output run, mem_ready, ir,
      input  PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin, Yin,
      input  Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
      input  rout_en, rout_sel, rin_en, rin_sel, ALU, busy, halted
   );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired Moore control unit. Fetches an instruction, decodes
//                IR and steps the datapath through 3-operand ALU ops or
//                MUL/DIV (result split into LO/HI).
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
   parameter int OPW  = 5,
   parameter int REGW = 4
) (
   input  wire                   clock,
   input  wire                   clear,
   control_sequencer_if.master   bus
);

   localparam logic [OPW-1:0] OP_ADD = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_AND = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR  = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_MUL = OPW'(5'b01111);
   localparam logic [OPW-1:0] OP_DIV = OPW'(5'b10000);

   // T1 is split in two so PCin fires only on the first fetch-wait cycle.
   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_T0      = 4'd1,
      S_T1      = 4'd2,
      S_T1_WAIT = 4'd3,
      S_T2      = 4'd4,
      S_T3      = 4'd5,
      S_T4      = 4'd6,
      S_T5      = 4'd7,
      S_T6      = 4'd8,
      S_HALT    = 4'd9
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [OPW-1:0]    w_opcode;
   logic [REGW-1:0]   w_ra, w_rb, w_rc;
   logic              w_is_3op;
   logic              w_is_muldiv;
   logic [OPW-1:0]    w_alu_code;

   assign w_opcode = bus.ir[31 -: OPW];
   assign w_ra     = bus.ir[31-OPW -: REGW];
   assign w_rb     = bus.ir[31-OPW-REGW -: REGW];
   assign w_rc     = bus.ir[31-OPW-2*REGW -: REGW];

   // Opcode classification and ALU function lookup
   always_comb begin
      w_is_3op    = 1'b0;
      w_is_muldiv = 1'b0;
      w_alu_code  = '0;
      case (w_opcode)
         OP_ADD: begin w_is_3op    = 1'b1; w_alu_code = OPW'(5'b00011); end
         OP_SUB: begin w_is_3op    = 1'b1; w_alu_code = OPW'(5'b00100); end
         OP_AND: begin w_is_3op    = 1'b1; w_alu_code = OPW'(5'b00101); end
         OP_OR : begin w_is_3op    = 1'b1; w_alu_code = OPW'(5'b00110); end
         OP_MUL: begin w_is_muldiv = 1'b1; w_alu_code = OPW'(5'b00010); end
         OP_DIV: begin w_is_muldiv = 1'b1; w_alu_code = OPW'(5'b00001); end
         default: ;
      endcase
   end

   // State register; clear overrides everything, even mid-instruction
   always_ff @(posedge clock) begin
      if (clear)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state and Moore output decode
   always_comb begin
      w_next       = r_state;
      bus.PCout    = 1'b0;
      bus.MARin    = 1'b0;
      bus.IncPC    = 1'b0;
      bus.PCin     = 1'b0;
      bus.read     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zlowin   = 1'b0;
      bus.Zhighin  = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.LOin     = 1'b0;
      bus.HIin     = 1'b0;
      bus.rout_en  = 1'b0;
      bus.rout_sel = '0;
      bus.rin_en   = 1'b0;
      bus.rin_sel  = '0;
      bus.ALU      = '0;
      bus.busy     = (r_state != S_IDLE) && (r_state != S_HALT);
      bus.halted   = (r_state == S_HALT);

      case (r_state)
         S_IDLE: begin
            if (bus.run)
               w_next = S_T0;
         end
         S_T0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.Zlowin = 1'b1;
            w_next     = S_T1;
         end
         S_T1, S_T1_WAIT: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = (r_state == S_T1);
            bus.read    = 1'b1;
            bus.MDRin   = 1'b1;
            w_next      = bus.mem_ready ? S_T2 : S_T1_WAIT;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            w_next     = S_T3;
         end
         S_T3: begin
            if (w_is_3op || w_is_muldiv) begin
               bus.rout_en  = 1'b1;
               bus.rout_sel = w_is_3op ? w_rb : w_ra;
               bus.Yin      = 1'b1;
               w_next       = S_T4;
            end else begin
               w_next       = S_HALT;
            end
         end
         S_T4: begin
            bus.rout_en  = 1'b1;
            bus.rout_sel = w_is_3op ? w_rc : w_rb;
            bus.ALU      = w_alu_code;
            bus.Zlowin   = 1'b1;
            bus.Zhighin  = 1'b1;
            w_next       = S_T5;
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (w_is_3op) begin
               bus.rin_en  = 1'b1;
               bus.rin_sel = w_ra;
               w_next      = bus.run ? S_T0 : S_IDLE;
            end else begin
               bus.LOin    = 1'b1;
               w_next      = S_T6;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            w_next       = bus.run ? S_T0 : S_IDLE;
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer: directed scenarios
//                plus randomized run/mem_ready/clear/IR traffic compared each
//                cycle against an instruction-schedule model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.master)
   );

   localparam logic [31:0] IR_ADD  = 32'h18918000;  // ADD r1,r2,r3
   localparam logic [31:0] IR_MUL  = 32'h7B380000;  // MUL r6,r7
   localparam logic [31:0] IR_BAD  = 32'hF8000000;  // opcode 11111

   int total = 0;
   int bad   = 0;

   logic [31:0] w_dut;
   assign w_dut = {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.read, bus.MDRin,
                   bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin,
                   bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin,
                   bus.rout_en, bus.rout_sel, bus.rin_en, bus.rin_sel,
                   bus.ALU, bus.busy, bus.halted};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode 0 idle, 1 executing an instruction, 2 halted.
   // step counts cycles of the instruction schedule: 0 address, 1 memory
   // read (repeats while memory not ready), 2 IR load, 3.. execute steps.
   int m_mode  = 0;
   int m_step  = 0;
   bit m_first = 1'b0;
   bit m_valid = 1'b0;

   // 0 unknown, 1 three-operand, 2 MUL/DIV
   function automatic int op_class(input logic [31:0] ir);
      logic [4:0] op;
      op = ir[31:27];
      if (op == 5'd3 || op == 5'd4 || op == 5'd5 || op == 5'd6) return 1;
      if (op == 5'd15 || op == 5'd16) return 2;
      return 0;
   endfunction

   function automatic logic [4:0] alu_of(input logic [31:0] ir);
      case (ir[31:27])
         5'd15:   return 5'd2;
         5'd16:   return 5'd1;
         default: return ir[31:27];
      endcase
   endfunction

   function automatic logic [31:0] model_word(input int md, input int st,
                                              input bit first, input logic [31:0] ir);
      logic pco, mar, inc, pci, rd, mdi, mdo, iri, yi, zli, zhi, zlo, zho, loi, hii;
      logic ren, wen, bsy, hlt;
      logic [3:0] rs, ws;
      logic [4:0] al;
      int cls;
      {pco, mar, inc, pci, rd, mdi, mdo, iri, yi, zli, zhi, zlo, zho, loi, hii} = '0;
      {ren, wen, bsy, hlt} = '0;
      rs = '0; ws = '0; al = '0;
      cls = op_class(ir);
      if (md == 2) hlt = 1'b1;
      else if (md == 1) begin
         bsy = 1'b1;
         case (st)
            0: {pco, mar, inc, zli} = 4'b1111;
            1: begin zlo = 1; pci = first; rd = 1; mdi = 1; end
            2: {mdo, iri} = 2'b11;
            3: if (cls != 0) begin
                  ren = 1; yi = 1;
                  rs = (cls == 1) ? ir[22:19] : ir[26:23];
               end
            4: begin
                  ren = 1; zli = 1; zhi = 1; al = alu_of(ir);
                  rs = (cls == 1) ? ir[18:15] : ir[22:19];
               end
            5: begin
                  zlo = 1;
                  if (cls == 1) begin wen = 1; ws = ir[26:23]; end
                  else loi = 1;
               end
            6: {zho, hii} = 2'b11;
            default: ;
         endcase
      end
      return {pco, mar, inc, pci, rd, mdi, mdo, iri, yi, zli, zhi, zlo, zho, loi, hii,
              ren, rs, wen, ws, al, bsy, hlt};
   endfunction

   // Per-cycle compare on the falling edge, then advance the model with the
   // inputs that the next rising edge will sample.
   initial begin
      forever begin
         @(negedge clock);
         if (m_valid) begin
            chk("cycle_outputs", w_dut, model_word(m_mode, m_step, m_first, bus.ir));
            total++;
            if ((32'(bus.PCout) + 32'(bus.MDRout) + 32'(bus.Zlowout) +
                 32'(bus.Zhighout) + 32'(bus.rout_en)) > 32'd1) begin
               bad++;
               $display("FAIL bus_drivers: got %b allowed at most one (t=%0t)",
                        {bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.rout_en}, $time);
            end
         end
         if (clear) begin
            m_mode  = 0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            if (m_mode == 0) begin
               if (bus.run) begin m_mode = 1; m_step = 0; end
            end else if (m_mode == 1) begin
               case (m_step)
                  0: begin m_step = 1; m_first = 1'b1; end
                  1: begin m_first = 1'b0; if (bus.mem_ready) m_step = 2; end
                  2: m_step = 3;
                  3: if (op_class(bus.ir) == 0) m_mode = 2; else m_step = 4;
                  4: m_step = 5;
                  default: begin
                     if (m_step == 5 && op_class(bus.ir) == 2) m_step = 6;
                     else if (bus.run) m_step = 0;
                     else m_mode = 0;
                  end
               endcase
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int n, n_rd, n_pc, n_inc, cyc;
      logic seen;
      logic [31:0] r;
      logic [4:0] ops [6];
      ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16};

      clear = 1'b1; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
      tick(); tick();
      chk("reset_outputs", w_dut, 32'h0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      clear = 1'b0;

      // ADD r1,r2,r3 with immediate memory
      bus.ir = IR_ADD; bus.mem_ready = 1'b1; bus.run = 1'b1;
      tick(); chk("add_t0_pcout", 32'(bus.PCout), 32'd1);
      tick(); chk("add_t1_pcin", 32'(bus.PCin), 32'd1);
      tick(); chk("add_t2_irin", 32'(bus.IRin), 32'd1);
      tick(); chk("add_t3_rsel", 32'(bus.rout_sel), 32'd2);
              chk("add_t3_yin", 32'(bus.Yin), 32'd1);
      tick(); chk("add_t4_rsel", 32'(bus.rout_sel), 32'd3);
              chk("add_t4_alu", 32'(bus.ALU), 32'd3);
      tick(); chk("add_t5_rin", {bus.rin_en, bus.rin_sel}, 32'h11);
      tick(); chk("add_next_t0", 32'(bus.PCout), 32'd1);

      // MUL r6,r7: seven cycles T0..T6 then back to T0
      bus.ir = IR_MUL;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 3) chk("mul_t3_rsel", 32'(bus.rout_sel), 32'd6);
         if (i == 4) chk("mul_t4_rsel_alu", {bus.rout_sel, bus.ALU}, {4'd7, 5'd2});
         if (i == 5) chk("mul_t5_lo", {bus.Zlowout, bus.LOin, bus.HIin}, 32'b110);
         if (i == 6) chk("mul_t6_hi", {bus.Zhighout, bus.HIin, bus.LOin}, 32'b110);
         if (i == 7) chk("mul_next_t0", 32'(bus.PCout), 32'd1);
      end

      // Memory waits: three not-ready cycles stretch T1 to four cycles
      bus.ir = IR_ADD; bus.mem_ready = 1'b0; bus.run = 1'b0;
      n_rd = 0; n_pc = 0; n_inc = 32'(bus.IncPC); cyc = 1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (!bus.busy) break;
         cyc++;
         n_rd  += 32'(bus.read);
         n_pc  += 32'(bus.PCin);
         n_inc += 32'(bus.IncPC);
         bus.mem_ready = (n_rd >= 4);
      end
      chk("wait_cycles", cyc, 9);
      chk("wait_read_cycles", n_rd, 4);
      chk("wait_pcin_pulses", n_pc, 1);
      chk("wait_incpc_pulses", n_inc, 1);
      chk("wait_end_idle", w_dut, 32'h0);

      // Unknown opcode halts; run toggles ignored; clear recovers
      bus.ir = IR_BAD; bus.run = 1'b1; bus.mem_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); n++;
         if (bus.halted) break;
      end
      chk("halt_latency", n, 5);
      for (int i = 0; i < 6; i++) begin
         bus.run = i[0];
         tick();
         chk("halt_hold", w_dut, 32'h1);
      end
      clear = 1'b1; bus.run = 1'b0;
      tick();
      clear = 1'b0;
      chk("halt_clear_idle", w_dut, 32'h0);

      // clear during T4 of a MUL aborts it before LO/HI are written
      bus.ir = IR_MUL; bus.run = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("abort_t4_alu", 32'(bus.ALU), 32'd2);
      clear = 1'b1;
      tick();
      chk("abort_idle", w_dut, 32'h0);
      clear = 1'b0; bus.run = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen |= bus.LOin | bus.HIin;
      end
      chk("abort_no_lo_hi", 32'(seen), 32'd0);

      // Randomized traffic; IR only changes outside the execute steps
      for (int i = 0; i < 4000; i++) begin
         tick();
         clear         = ($urandom_range(0, 63) == 0);
         bus.run       = ($urandom_range(0, 7) != 0);
         bus.mem_ready = $urandom_range(0, 1);
         if (m_mode != 1 || m_step <= 2) begin
            r = $urandom();
            if ($urandom_range(0, 15) == 0)
               bus.ir = r;
            else
               bus.ir = {ops[$urandom_range(0, 5)], r[26:0]};
         end
      end
      clear = 1'b1;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
